spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_WIDTH, 12, instruction word address width.
- DATA_WIDTH, 16, instruction width; a multiple of 8.
- CLK_DIV, 2, clk cycles per SCLK half-period; valid when >= 1.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single system clock; all logic on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- req, input, 1, fetch request from the program counter side.
- addr, input, ADDR_WIDTH, instruction word address to fetch.
- flash_ready, output, 1, one-cycle pulse: instr valid.
- busy, output, 1, transaction in progress.
- instr, output, DATA_WIDTH, last fetched instruction.
- spi_cs_n, output, 1, flash chip select, active low.
- spi_sclk, output, 1, SPI clock, mode 0.
- spi_mosi, output, 1, serial command/address out.
- spi_miso, input, 1, serial data in.

Function
REQ-003 FSM states SHALL be IDLE, CMD, ADDR, DATA, DONE.
REQ-004 In IDLE with req=1, the block SHALL capture addr, set busy=1 and enter CMD on the next cycle, with spi_cs_n low from that cycle.
REQ-005 req SHALL be ignored while busy=1; no queuing.
REQ-006 The command byte SHALL be 0x03 (READ), MSB first.
REQ-007 The 24-bit byte address sent in ADDR SHALL be the zero-extended addr multiplied by DATA_WIDTH/8, MSB first; upper bits are zero.
REQ-008 Each SPI bit SHALL take 2*CLK_DIV clk cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-009 spi_mosi SHALL change only while SCLK is low.
REQ-010 spi_miso SHALL be sampled on the clk cycle where SCLK rises.
REQ-011 DATA SHALL shift in DATA_WIDTH bits MSB first; spi_mosi SHALL be 0 during DATA.
REQ-012 In DONE, spi_cs_n SHALL be high, instr SHALL be loaded, flash_ready=1 for exactly one cycle, and the FSM SHALL return to IDLE; busy SHALL drop the same cycle.
REQ-013 Latency SHALL be fixed: flash_ready asserts exactly (32+DATA_WIDTH)*2*CLK_DIV + 2 cycles after the edge that accepted req.
REQ-014 A req asserted in the DONE cycle SHALL be ignored; it is accepted only from IDLE. spi_cs_n stays high for at least 1 cycle between transactions.
REQ-015 instr SHALL hold its value between transactions and change only in DONE.
REQ-016 Bit and divider counters SHALL wrap cleanly per phase, with no carry between phases.
REQ-017 When idle, spi_sclk SHALL be 0 (mode 0).

Reset
REQ-018 While rst=1, the block SHALL hold: state=IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, flash_ready=0, instr=0, and all counters 0.
REQ-019 rst asserted mid-transaction SHALL abort on the next edge: spi_cs_n=1 and no flash_ready pulse.
REQ-020 The first req after rst deasserts SHALL be accepted normally.

Structure
REQ-021 The shared package SHALL hold the FSM state encoding and the SPI_CMD_READ = 8'h03 constant.
REQ-022 One sub-module, spi_clk_div (CLK_DIV counter generating the SCLK rise/fall strobes), SHALL be used; all other logic stays in spi_flash_reader.

Verification
REQ-023 Basic fetch: CLK_DIV=2, addr=0x123, flash model returns 0xA55A -> MOSI carries 0x03 then 0x000246, instr=0xA55A, single flash_ready pulse 194 cycles after accept.
REQ-024 Back-to-back: req held high across addr 0x000 and 0x001 -> two transactions with byte addresses 0x000000 and 0x000002; spi_cs_n high >= 1 cycle between them; exactly two pulses.
REQ-025 Busy ignore: second req with addr=0x055 pulsed mid-DATA -> ignored; only the first fetch completes; instr is from the first address.
REQ-026 Reset abort: rst=1 during ADDR bit 10 -> next cycle spi_cs_n=1, busy=0, no flash_ready, instr unchanged at 0.
REQ-027 Max address and divider: CLK_DIV=1, addr=0xFFF, model returns 0xFFFF -> byte address 0x001FFE, instr=0xFFFF, latency 98 cycles.
REQ-028 Mode check: a protocol assertion SHALL confirm spi_mosi never toggles while spi_sclk=1 and spi_sclk=0 whenever spi_cs_n=1.

Source files
------------

// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI instruction-fetch reader: FSM encoding,
// flash command constant and byte-address helper.
package spi_flash_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    // Flash is byte addressed; instruction words are bytes_per_word wide.
    function automatic logic [23:0] byte_address(input logic [23:0] word_addr,
                                                 input int bytes_per_word);
        return word_addr * 24'(bytes_per_word);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: CLK_DIV clk cycles per half-period, low half first (mode 0).
// Strobes flag the last clk cycle of each half, i.e. the edge where SCLK toggles.
module spi_clk_div
    import spi_flash_reader_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          sclk_q;
    logic          half_end;

    assign half_end  = (cnt_q == CW'(CLK_DIV - 1));
    assign sclk_rise = en & ~sclk_q & half_end;
    assign sclk_fall = en &  sclk_q & half_end;
    assign sclk      = sclk_q;

    // Dropping en parks SCLK low with a cleared counter, so every phase restarts clean.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (half_end) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// Fetches one instruction word per request from a SPI NOR flash using the
// READ (0x03) command with a 24-bit byte address, SPI mode 0.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  flash_ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  spi_cs_n,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int CNT_MAX = (DATA_WIDTH + 1 > 23) ? DATA_WIDTH + 1 : 23;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                state_q, state_d;
    logic [31:0]           tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [CNT_W-1:0]      bit_q;
    logic                  div_en;
    logic                  sclk_rise;
    logic                  sclk_fall;

    // DATA keeps the divider off for two trailing cycles after the last bit,
    // holding chip select low before DONE.
    assign div_en = (state_q == CMD) || (state_q == ADDR) ||
                    ((state_q == DATA) && (bit_q < CNT_W'(DATA_WIDTH)));

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en),
        .sclk      (spi_sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = CMD;
            CMD:  if (sclk_fall && bit_q == CNT_W'(7)) state_d = ADDR;
            ADDR: if (sclk_fall && bit_q == CNT_W'(23)) state_d = DATA;
            DATA: if (bit_q == CNT_W'(DATA_WIDTH + 1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            instr_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        tx_q  <= {SPI_CMD_READ, byte_address(24'(addr), DATA_WIDTH / 8)};
                        bit_q <= '0;
                    end
                end
                CMD, ADDR: begin
                    // Shift on the falling edge so MOSI only moves while SCLK is low.
                    if (sclk_fall) begin
                        tx_q  <= {tx_q[30:0], 1'b0};
                        bit_q <= (state_d != state_q) ? '0 : bit_q + 1'b1;
                    end
                end
                DATA: begin
                    if (sclk_rise) rx_q <= {rx_q[DATA_WIDTH-2:0], spi_miso};
                    if (sclk_fall || bit_q >= CNT_W'(DATA_WIDTH)) bit_q <= bit_q + 1'b1;
                    if (state_d == DONE) instr_q <= rx_q;
                end
                DONE: bit_q <= '0;
                default: bit_q <= '0;
            endcase
        end
    end

    assign busy        = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign spi_cs_n    = ~busy;
    assign flash_ready = (state_q == DONE);
    assign spi_mosi    = ((state_q == CMD) || (state_q == ADDR)) ? tx_q[31] : 1'b0;
    assign instr       = instr_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1) against a
// behavioural flash device and a transaction-level scoreboard.
module tb_spi_flash_reader;

    localparam int DW = 16;

    typedef struct {
        logic [15:0] data;
        logic [23:0] baddr;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_v   [2];
    logic [11:0] addr_v  [2];
    logic        rdy_v   [2];
    logic        busy_v  [2];
    logic        cs_v    [2];
    logic        sclk_v  [2];
    logic        mosi_v  [2];
    logic [15:0] instr_v [2];
    logic [31:0] hdr_v   [2];
    int          perr_v  [2];

    logic [15:0] word_mem [0:4095];
    exp_t        q [2][$];
    int          cyc = 0;
    logic        rst_q = 1'b1;
    int          next_ok [2] = '{0, 0};
    logic [15:0] last_instr [2] = '{16'h0, 16'h0};
    int          n_checks = 0;
    int          n_pass = 0;
    logic        stim_done = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int CD = (g == 0) ? 2 : 1;
        logic        miso = 1'b0;
        logic        prev_mosi = 1'b0;
        int          rc = 0;
        logic [31:0] hdr = '0;
        logic [15:0] dsr = '0;
        int          perr = 0;

        spi_flash_reader #(
            .ADDR_WIDTH (12),
            .DATA_WIDTH (DW),
            .CLK_DIV    (CD)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .req         (req_v[g]),
            .addr        (addr_v[g]),
            .flash_ready (rdy_v[g]),
            .busy        (busy_v[g]),
            .instr       (instr_v[g]),
            .spi_cs_n    (cs_v[g]),
            .spi_sclk    (sclk_v[g]),
            .spi_mosi    (mosi_v[g]),
            .spi_miso    (miso)
        );

        assign hdr_v[g]  = hdr;
        assign perr_v[g] = perr;

        // Flash device: latch command+address on SCLK rises, then shift data out on falls.
        always @(negedge cs_v[g] or posedge sclk_v[g]) begin
            if (!sclk_v[g]) begin
                rc  = 0;
                hdr = '0;
            end else if (!cs_v[g]) begin
                if (rc < 32) hdr = {hdr[30:0], mosi_v[g]};
                rc++;
            end
        end

        always @(negedge sclk_v[g]) begin
            if (rc == 32) dsr = word_mem[hdr[12:1]];
            if (rc >= 32 && rc < 32 + DW) begin
                miso = dsr[15];
                dsr  = {dsr[14:0], 1'b0};
            end else begin
                miso = 1'b0;
            end
        end

        always @(negedge clk) begin
            if (sclk_v[g] && mosi_v[g] !== prev_mosi) begin
                perr++;
                $display("FAIL mode_mosi inst%0d: mosi moved to %b while sclk high", g, mosi_v[g]);
            end
            if (cs_v[g] && sclk_v[g] !== 1'b0) begin
                perr++;
                $display("FAIL mode_sclk inst%0d: sclk=%b while cs_n high", g, sclk_v[g]);
            end
            prev_mosi = mosi_v[g];
        end
    end

    function automatic int lat(input int g);
        return (32 + DW) * 2 * ((g == 0) ? 2 : 1) + 2;
    endfunction

    // Reference model: a request is taken only when the reader is idle; it
    // answers lat() edges later and is free again two edges after that.
    always @(posedge clk) begin
        exp_t e;
        cyc   <= cyc + 1;
        rst_q <= rst;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                q[g].delete();
                next_ok[g] <= cyc + 2;
            end else if (req_v[g] && (cyc + 1 >= next_ok[g])) begin
                e.data  = word_mem[addr_v[g]];
                e.baddr = 24'(addr_v[g]) * 24'(DW / 8);
                e.due   = cyc + 1 + lat(g);
                q[g].push_back(e);
                next_ok[g] <= cyc + 1 + lat(g) + 2;
            end
        end
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", nm, g, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic bexp;
        if (stim_done) begin
            for (int g = 0; g < 2; g++) begin
                chk("pending_fetches", g, q[g].size(), 0);
                chk("mode_violations", g, perr_v[g], 0);
            end
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (rst_q) begin
                    chk("rst_cs_n", g, cs_v[g], 1);
                    chk("rst_sclk", g, sclk_v[g], 0);
                    chk("rst_mosi", g, mosi_v[g], 0);
                    chk("rst_busy", g, busy_v[g], 0);
                    chk("rst_ready", g, rdy_v[g], 0);
                    chk("rst_instr", g, instr_v[g], 0);
                    last_instr[g] = 16'h0;
                end else begin
                    bexp = (q[g].size() > 0) && (cyc < q[g][0].due);
                    chk("busy", g, busy_v[g], bexp);
                    chk("cs_n", g, cs_v[g], !bexp);
                    if (rdy_v[g]) begin
                        if (q[g].size() == 0) begin
                            chk("spurious_ready", g, rdy_v[g], 0);
                        end else begin
                            e = q[g].pop_front();
                            chk("latency_edge", g, cyc, e.due);
                            chk("instr", g, instr_v[g], e.data);
                            chk("cmd_byte", g, hdr_v[g][31:24], 8'h03);
                            chk("byte_addr", g, hdr_v[g][23:0], e.baddr);
                            last_instr[g] = e.data;
                        end
                    end else begin
                        if (q[g].size() > 0 && cyc >= q[g][0].due) begin
                            chk("ready_at_due", g, rdy_v[g], 1);
                            void'(q[g].pop_front());
                        end
                        chk("instr_hold", g, instr_v[g], last_instr[g]);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) word_mem[i] = 16'($urandom);
        word_mem[12'h123] = 16'hA55A;
        word_mem[12'hFFF] = 16'hFFFF;
        req_v  = '{1'b0, 1'b0};
        addr_v = '{12'h000, 12'h000};
        tick(4);
        rst = 1'b0;
        tick(3);

        // Basic fetch on the CLK_DIV=2 reader, max address on the CLK_DIV=1 reader.
        addr_v[0] = 12'h123; req_v[0] = 1'b1;
        addr_v[1] = 12'hFFF; req_v[1] = 1'b1;
        tick(1);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        tick(210);

        // Request held high across two consecutive addresses.
        addr_v[0] = 12'h000; req_v[0] = 1'b1;
        tick(1);
        addr_v[0] = 12'h001;
        tick(250);
        req_v[0] = 1'b0;
        tick(200);

        // Second request pulsed while the first is shifting data in.
        addr_v[0] = 12'($urandom); req_v[0] = 1'b1;
        tick(1);
        req_v[0] = 1'b0;
        tick(150);
        addr_v[0] = 12'h055; req_v[0] = 1'b1;
        tick(1);
        req_v[0] = 1'b0;
        tick(100);

        // Reset landing on address bit 10, then a normal fetch right after.
        addr_v[0] = 12'($urandom); req_v[0] = 1'b1;
        tick(1);
        req_v[0] = 1'b0;
        tick(72);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        addr_v[0] = 12'($urandom); req_v[0] = 1'b1;
        tick(1);
        req_v[0] = 1'b0;
        tick(210);

        // Random requests on both readers, including one stray reset.
        for (int i = 0; i < 3000; i++) begin
            for (int g = 0; g < 2; g++) begin
                req_v[g]  = ($urandom_range(0, 15) == 0);
                addr_v[g] = 12'($urandom);
            end
            rst = (i == 1500);
            tick(1);
        end
        req_v = '{1'b0, 1'b0};
        rst   = 1'b0;
        tick(220);
        stim_done = 1'b1;
    end

endmodule
